pdm_accum_recv: RTL and testbench
=================================

PDM_ACCUM_RECV -- requirements
Module: pdm_accum_recv

Interface
REQ-001 SHALL have parameter ACCUM_BITS, default 4: accumulator width; window length is 2^ACCUM_BITS-1 sample pairs.
REQ-002 SHALL have ports clk (input, 1, single system clock, 100 MHz nominal) and rst (input, 1, reset); reset is asynchronous and active-high.
REQ-003 SHALL have port mode (input, 1): 1 = full-rate PDM clock, 0 = low-rate PDM clock.
REQ-004 SHALL have port pdm_data (input, 1): asynchronous microphone data line shared by left and right.
REQ-005 SHALL have port sync (input, 1): synchronous window restart.
REQ-006 SHALL have port pdm_clk (output, 1): clock driven to the microphones.
REQ-007 SHALL have ports left and right (output, 1 each): most recent captured bit of each channel.
REQ-008 SHALL have port data_valid (output, 1): one-cycle strobe when a new left/right pair is present.
REQ-009 SHALL have ports left_accum and right_accum (output, ACCUM_BITS each): ones-count of the last completed window.
REQ-010 SHALL have port accum_valid (output, 1): one-cycle strobe when left_accum and right_accum update.

Function
REQ-011 SHALL divide clk by a half-period counter: H=16 when mode=1 (pdm_clk=clk/32), H=64 when mode=0 (clk/128).
REQ-012 SHALL toggle pdm_clk on the cycle the counter equals H-1; the counter then wraps to 0.
REQ-013 SHALL sample mode only at the wrap preceding a pdm_clk rising edge, so no half-period is truncated.
REQ-014 SHALL pass pdm_data through a 2-flop synchronizer before capture.
REQ-015 SHALL capture the synchronized bit on the counter=H-1 cycle: into left before a falling edge, into right before a rising edge.
REQ-016 SHALL pulse data_valid one cycle after the right capture, with left and right stable from that cycle until the next pair.
REQ-017 SHALL, on each data_valid, add left into the left count, add right into the right count, and increment a shared sample counter.
REQ-018 SHALL, when the sample counter reaches 2^ACCUM_BITS-1, do all of the following: load the counts into left_accum/right_accum, pulse accum_valid the next cycle, and clear the counts and sample counter.
REQ-019 SHALL never overflow: maximum count equals window length (15 for ACCUM_BITS=4).
REQ-020 SHALL, when sync=1, clear counts and the sample counter; a data_valid in the same cycle is discarded; accum outputs hold.
REQ-021 SHALL keep pdm_clk, left, right and data_valid running during sync.

Reset
REQ-022 SHALL, when rst=1, force every output to 0 (pdm_clk low, left, right, left_accum, right_accum, data_valid, accum_valid).
REQ-023 SHALL, when rst=1, clear all counters and synchronizer flops, and latch mode at release.
REQ-024 SHALL, on reset mid-window, drop the partial window without an accum_valid.

Configuration
REQ-025 SHALL, with PDM_SUM_EN defined, add output sum_accum (ACCUM_BITS+1 wide) = left+right ones over the same window, updated with accum_valid; without it, the port and logic are absent.

Structure
REQ-026 SHALL place the H constants (16, 64) and the synchronizer depth (2) in shared package pdm_rx_pkg.
REQ-027 SHALL implement the per-channel counter as one sub-module, accum_recv (data, sample_valid, sync -> accum_data, accum_clk), instantiated per channel.

Verification
REQ-028 SHALL verify: mode=1, after reset -> pdm_clk period 320 ns; data_valid every 32 clk cycles; mode=0 -> period 1280 ns.
REQ-029 SHALL verify: left bits 16'h1234 and right bits 16'h5432 driven LSB first (left after rising edge, right after falling edge) -> after 15 pairs left_accum=5, right_accum=6, accum_valid one pulse.
REQ-030 SHALL verify: pdm_data held at 1 for 15 pairs -> both accums = 15, no wrap to 0.
REQ-031 SHALL verify: sync pulsed after pair 7 -> next accum_valid comes 15 pairs after the sync, not 8.
REQ-032 SHALL verify: rst asserted mid-window -> all outputs 0 at once; the first accum_valid comes 15 pairs after release.
REQ-033 SHALL verify: mode toggled mid half-period -> no pdm_clk half-period shorter than 16 clk cycles.

Source files
------------

// File: rtl/pdm_accum_recv_pkg.sv
// Shared constants for the PDM receiver: PDM clock half-periods,
// synchronizer depth, and the PDM clock phase encoding.
package pdm_rx_pkg;

  localparam int unsigned H_FULL     = 16;  // half-period in clk cycles, mode=1
  localparam int unsigned H_LOW      = 64;  // half-period in clk cycles, mode=0
  localparam int unsigned SYNC_DEPTH = 2;   // flops ahead of the capture register
  localparam int unsigned HCNT_W     = $clog2(H_LOW);

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } pdm_phase_e;

  // Terminal count of the half-period counter for the given rate.
  function automatic logic [HCNT_W-1:0] half_last(input logic full_rate);
    return full_rate ? HCNT_W'(H_FULL - 1) : HCNT_W'(H_LOW - 1);
  endfunction

endpackage

// File: rtl/pdm_accum_recv_accum.sv
// Per-channel ones counter. Counts ones over a window of 2^ACCUM_BITS-1
// samples, then publishes the count on accum_data with a one-cycle
// accum_clk strobe. sync discards the partial window; accum_data holds.
module accum_recv
  import pdm_rx_pkg::*;
#(
  parameter int unsigned ACCUM_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data,
  input  logic                  sample_valid,
  input  logic                  sync,
  output logic [ACCUM_BITS-1:0] accum_data,
  output logic                  accum_clk
);

  logic [ACCUM_BITS-1:0] r_count;
  logic [ACCUM_BITS-1:0] r_samples;
  logic [ACCUM_BITS-1:0] r_accum;
  logic                  r_accum_clk;
  logic                  w_window_done;

  // Sample counter sitting at all-ones means the window is complete.
  assign w_window_done = (r_samples == '1);

  // Window accumulation: sync wins, then window close, then new sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_samples <= '0;
    end else if (sync) begin
      r_count   <= '0;
      r_samples <= '0;
    end else if (w_window_done) begin
      // A sample arriving on the close cycle opens the next window.
      r_count   <= sample_valid ? ACCUM_BITS'(data) : '0;
      r_samples <= sample_valid ? ACCUM_BITS'(1) : '0;
    end else if (sample_valid) begin
      r_count   <= r_count + ACCUM_BITS'(data);
      r_samples <= r_samples + ACCUM_BITS'(1);
    end
  end

  // Publish the completed window; strobe is high alongside the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_accum     <= '0;
      r_accum_clk <= 1'b0;
    end else begin
      r_accum_clk <= 1'b0;
      if (!sync && w_window_done) begin
        r_accum     <= r_count;
        r_accum_clk <= 1'b1;
      end
    end
  end

  assign accum_data = r_accum;
  assign accum_clk  = r_accum_clk;

endmodule

// File: rtl/pdm_accum_recv.sv
// Stereo PDM microphone receiver: generates pdm_clk from clk, captures
// left on the falling edge and right on the rising edge, and counts ones
// per channel over fixed windows.
// Optional feature: define PDM_SUM_EN to add the sum_accum output.
module pdm_accum_recv
  import pdm_rx_pkg::*;
#(
  parameter int unsigned ACCUM_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  pdm_data,
  input  logic                  sync,
  output logic                  pdm_clk,
  output logic                  left,
  output logic                  right,
  output logic                  data_valid,
  output logic [ACCUM_BITS-1:0] left_accum,
  output logic [ACCUM_BITS-1:0] right_accum,
`ifdef PDM_SUM_EN
  output logic [ACCUM_BITS:0]   sum_accum,
`endif
  output logic                  accum_valid
);

  logic [SYNC_DEPTH-1:0] r_sync;
  logic                  r_first;
  logic                  r_mode;
  logic [HCNT_W-1:0]     r_cnt;
  pdm_phase_e            r_phase;
  pdm_phase_e            w_phase_nxt;
  logic                  w_mode_eff;
  logic                  w_wrap;
  logic                  w_cap_left;
  logic                  w_cap_right;
  logic                  w_bit;
  logic                  r_left_cap;
  logic                  r_have_left;
  logic                  r_left;
  logic                  r_right;
  logic                  r_dv;
  logic                  w_l_aclk;
  logic                  w_r_aclk;

  // On the first cycle after reset the live mode pin sets the rate, which
  // is the same value r_mode latches on that cycle.
  assign w_mode_eff = r_first ? mode : r_mode;
  assign w_wrap     = (r_cnt == half_last(w_mode_eff));
  assign w_bit      = r_sync[SYNC_DEPTH-1];
  assign pdm_clk    = (r_phase == PH_HIGH);

  // Next PDM clock phase and capture strobes at the half-period boundary.
  always_comb begin
    w_phase_nxt = r_phase;
    w_cap_left  = 1'b0;
    w_cap_right = 1'b0;
    if (w_wrap) begin
      case (r_phase)
        PH_LOW: begin
          w_phase_nxt = PH_HIGH;
          w_cap_right = 1'b1;
        end
        PH_HIGH: begin
          w_phase_nxt = PH_LOW;
          w_cap_left  = 1'b1;
        end
        default: w_phase_nxt = PH_LOW;
      endcase
    end
  end

  // PDM clock phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_phase <= PH_LOW;
    else     r_phase <= w_phase_nxt;
  end

  // Half-period counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + HCNT_W'(1);
  end

  // Rate selection: latched at reset release and at each rising-edge wrap,
  // so every full PDM period runs at a single rate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first <= 1'b1;
      r_mode  <= 1'b0;
    end else begin
      r_first <= 1'b0;
      if (r_first || (w_wrap && (r_phase == PH_LOW))) r_mode <= mode;
    end
  end

  // Input synchronizer for the asynchronous microphone line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_DEPTH-2:0], pdm_data};
  end

  // Channel capture. Left is held until its right partner arrives so both
  // outputs change together with data_valid; a right bit with no preceding
  // left (first rising edge after reset) does not form a pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_left_cap  <= 1'b0;
      r_have_left <= 1'b0;
      r_left      <= 1'b0;
      r_right     <= 1'b0;
      r_dv        <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      if (w_cap_left) begin
        r_left_cap  <= w_bit;
        r_have_left <= 1'b1;
      end
      if (w_cap_right && r_have_left) begin
        r_left  <= r_left_cap;
        r_right <= w_bit;
        r_dv    <= 1'b1;
      end
    end
  end

  assign left       = r_left;
  assign right      = r_right;
  assign data_valid = r_dv;

  // Both channel counters see identical sample_valid/sync streams, so their
  // sample counters advance in lockstep and close windows together.
  accum_recv #(
    .ACCUM_BITS(ACCUM_BITS)
  ) u_left_accum (
    .clk         (clk),
    .rst         (rst),
    .data        (r_left),
    .sample_valid(r_dv),
    .sync        (sync),
    .accum_data  (left_accum),
    .accum_clk   (w_l_aclk)
  );

  accum_recv #(
    .ACCUM_BITS(ACCUM_BITS)
  ) u_right_accum (
    .clk         (clk),
    .rst         (rst),
    .data        (r_right),
    .sample_valid(r_dv),
    .sync        (sync),
    .accum_data  (right_accum),
    .accum_clk   (w_r_aclk)
  );

  assign accum_valid = w_l_aclk & w_r_aclk;

`ifdef PDM_SUM_EN
  // Both accumulators update on the same cycle, so the sum follows them.
  assign sum_accum = {1'b0, left_accum} + {1'b0, right_accum};
`endif

endmodule

// File: tb/tb_pdm_accum_recv.sv
// Self-checking bench for pdm_accum_recv with a window-level model.
module tb_pdm_accum_recv;

  localparam int unsigned AB  = 4;
  localparam int          WIN = (1 << AB) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic          pdm_data;
  logic          sync;
  logic          pdm_clk;
  logic          left;
  logic          right;
  logic          data_valid;
  logic [AB-1:0] left_accum;
  logic [AB-1:0] right_accum;
  logic          accum_valid;
`ifdef PDM_SUM_EN
  logic [AB:0]   sum_accum;
`endif

  always #5 clk = ~clk;

  pdm_accum_recv #(
    .ACCUM_BITS(AB)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .pdm_data   (pdm_data),
    .sync       (sync),
    .pdm_clk    (pdm_clk),
    .left       (left),
    .right      (right),
    .data_valid (data_valid),
    .left_accum (left_accum),
    .right_accum(right_accum),
`ifdef PDM_SUM_EN
    .sum_accum  (sum_accum),
`endif
    .accum_valid(accum_valid)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_ge(input string name, input longint act, input longint lim);
    n_total++;
    if (act >= lim) n_pass++;
    else $display("FAIL %s: got %0d expected at least %0d", name, act, lim);
  endtask

  // Microphone model: drives left after each rising pdm_clk edge and right
  // after each falling edge, and records every complete pair it sent.
  typedef struct {
    logic l;
    logic r;
  } pair_t;
  pair_t      q[$];
  logic [15:0] lpat;
  logic [15:0] rpat;
  int          k;
  logic        drv_l;
  bit          drv_have;
  logic        drv_prev;

  always @(negedge clk) begin
    if (rst) begin
      k        = 0;
      drv_have = 0;
      drv_prev = 1'b0;
      pdm_data = 1'b0;
    end else begin
      if (pdm_clk && !drv_prev) begin
        drv_l    = lpat[k % 16];
        pdm_data = drv_l;
        drv_have = 1;
      end else if (!pdm_clk && drv_prev) begin
        pdm_data = rpat[k % 16];
        if (drv_have) q.push_back('{drv_l, rpat[k % 16]});
        k++;
      end
      drv_prev = pdm_clk;
    end
  end

  // Reference model and per-cycle compare.
  longint cyc = 0;
  longint last_tog = -1;
  longint last_rise_t = -1;
  longint last_period_ns = 0;
  longint last_dv = -1;
  longint av_at = -1;
  logic   prev_pclk = 1'b0;
  int     exp_half = 0;
  int     m_l = 0, m_r = 0, m_n = 0;
  int     pend_l = 0, pend_r = 0;
  int     m_lacc = 0, m_racc = 0;
  logic   m_left = 1'b0, m_right = 1'b0;
  int     av_count = 0;
  int     dv_since_mark = 0;
  int     av_mark = -1;
  pair_t  p;
  bit     rose, exp_dv, exp_av;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      prev_pclk = 1'b0; last_tog = -1; last_rise_t = -1; last_dv = -1;
      m_l = 0; m_r = 0; m_n = 0; av_at = -1;
      m_lacc = 0; m_racc = 0; m_left = 1'b0; m_right = 1'b0;
      dv_since_mark = 0;
      chk("reset_outputs", {pdm_clk, left, right, data_valid, accum_valid, left_accum, right_accum}, 0);
    end else begin
      rose = pdm_clk && !prev_pclk;
      if (pdm_clk !== prev_pclk) begin
        if (last_tog >= 0) begin
          chk_ge("half_min", cyc - last_tog, 16);
          if (exp_half != 0) chk("half_len", cyc - last_tog, exp_half);
        end
        last_tog = cyc;
      end
      if (rose) begin
        if (last_rise_t >= 0 && exp_half != 0) begin
          last_period_ns = $time - last_rise_t;
          chk("pdm_period_ns", last_period_ns, exp_half * 20);
        end
        last_rise_t = $time;
      end
      prev_pclk = pdm_clk;

      exp_dv = rose && (q.size() > 0);
      chk("data_valid", data_valid, exp_dv);
      if (exp_dv) begin
        p = q.pop_front();
        m_left  = p.l;
        m_right = p.r;
        if (last_dv >= 0 && exp_half != 0) chk("dv_gap", cyc - last_dv, 2 * exp_half);
        last_dv = cyc;
      end
      chk("left", left, m_left);
      chk("right", right, m_right);

      exp_av = (av_at == cyc);
      if (exp_av) begin
        m_lacc = pend_l;
        m_racc = pend_r;
        av_count++;
        av_mark = dv_since_mark;
        dv_since_mark = 0;
      end
      chk("accum_valid", accum_valid, exp_av);
      chk("left_accum", left_accum, m_lacc);
      chk("right_accum", right_accum, m_racc);
`ifdef PDM_SUM_EN
      chk("sum_accum", sum_accum, m_lacc + m_racc);
`endif

      if (sync) begin
        m_l = 0; m_r = 0; m_n = 0; dv_since_mark = 0;
        if (av_at > cyc) av_at = -1;
      end else if (exp_dv) begin
        m_l += int'(p.l);
        m_r += int'(p.r);
        m_n++;
        dv_since_mark++;
        if (m_n == WIN) begin
          pend_l = m_l; pend_r = m_r; av_at = cyc + 2;
          m_l = 0; m_r = 0; m_n = 0;
        end
      end
    end
  end

  task automatic wait_dv(input int n, input int budget, input string name);
    int seen = 0;
    int c = 0;
    while (seen < n && c < budget) begin
      @(negedge clk);
      c++;
      if (data_valid) seen++;
    end
    chk(name, seen, n);
  endtask

  task automatic wait_av(input int budget, input string name);
    int   c = 0;
    logic got = 1'b0;
    while (!got && c < budget) begin
      @(negedge clk);
      c++;
      got = accum_valid;
    end
    chk(name, got, 1'b1);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic new_mode, input logic [15:0] lp, input logic [15:0] rp, input int half);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async_zero", {pdm_clk, left, right, data_valid, accum_valid, left_accum, right_accum}, 0);
    repeat (3) @(negedge clk);
    mode = new_mode; lpat = lp; rpat = rp; exp_half = half;
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b1; sync = 1'b0; lpat = 16'h1234; rpat = 16'h5432; exp_half = 16;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;

    // Pattern window: 15 LSB-first bits of 0x1234 -> 5 ones, 0x5432 -> 6 ones.
    wait_av(700, "t1_av_seen");
    chk("t1_left_accum", left_accum, 5);
    chk("t1_right_accum", right_accum, 6);
    chk("t1_av_single", accum_valid, 0);
    chk("t1_av_count", av_count, 1);
    chk("t1_period_ns", last_period_ns, 320);

    // All ones: full count, and the count must not wrap.
    do_reset(1'b1, 16'hFFFF, 16'hFFFF, 16);
    wait_av(700, "t2_av_seen");
    chk("t2_left_accum", left_accum, 15);
    chk("t2_right_accum", right_accum, 15);
    wait_av(700, "t2_av2_seen");
    chk("t2_left_accum2", left_accum, 15);
    chk("t2_right_accum2", right_accum, 15);

    // sync after pair 7: the next window is a full 15 pairs after it.
    do_reset(1'b1, 16'h1234, 16'h5432, 16);
    wait_dv(7, 400, "t3_seven_pairs");
    #2 sync = 1'b1;
    @(negedge clk);
    #2 sync = 1'b0;
    wait_av(700, "t3_av_seen");
    chk("t3_pairs_after_sync", av_mark, 15);

    // Reset mid-window: partial window dropped, full window after release.
    wait_dv(5, 300, "t4_five_pairs");
    do_reset(1'b1, 16'hA5C3, 16'h0F0F, 16);
    wait_av(700, "t4_av_seen");
    chk("t4_pairs_after_rst", av_mark, 15);

    // Low rate.
    do_reset(1'b0, 16'h1234, 16'h5432, 64);
    wait_dv(4, 700, "t5_dv_low_rate");
    chk("t5_period_ns", last_period_ns, 1280);

    // Mode flips at arbitrary points: no half-period may be cut short.
    exp_half = 0;
    for (int i = 0; i < 6; i++) begin
      repeat (7 + 13 * i) @(negedge clk);
      mode = ~mode;
    end
    mode = 1'b1;
    wait_dv(3, 600, "t6_settle");
    exp_half = 16;
    wait_dv(4, 300, "t6_full_rate");
    chk("t6_period_ns", last_period_ns, 320);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

endmodule
